// File: rtl/cdb_sched_pkg.sv
// cdb_sched_pkg -- shared types and constants for the CDB scheduler.
//   clog2()       : index width helper (never returns less than 1)
//   DEF_UNIT_LAT  : default per-unit latencies {div, mult, ls, int}, unit 0 in LSBs
//   slot_t        : reservation ring entry {valid, owner}
package cdb_sched_pkg;

    // Owner field is sized for the largest supported unit count (8).
    localparam int unsigned OWNER_W = 3;

    localparam logic [15:0] DEF_UNIT_LAT = {4'd6, 4'd3, 4'd1, 4'd1};

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } slot_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cdb_sched_arb.sv
// cdb_sched_arb -- picks exactly one winner among units contending for the
// same CDB reservation slot.
//   Build option CDB_SCHED_RR_EN: round-robin starting at ptr, and reports
//   whether more than one unit was requesting (contested). Without it the
//   lowest requesting index wins and the ptr/contested ports do not exist.
// Ports:
//   req       in  N              eligible requesters sharing one slot
//   ptr       in  clog2(N)       round-robin start index (RR build only)
//   contested out 1              >1 requester this cycle (RR build only)
//   gnt       out N              one-hot winner, or zero
module cdb_sched_arb
    import cdb_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
`ifdef CDB_SCHED_RR_EN
    input  logic [clog2(N)-1:0]   ptr,
    output logic                  contested,
`endif
    output logic [N-1:0]          gnt
);

`ifdef CDB_SCHED_RR_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign contested = (req & (req - N'(1))) != '0;

    always_comb begin
        logic found;
        int unsigned idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
`endif

endmodule

// File: rtl/cdb_sched.sv
// cdb_sched -- common-data-bus scheduler. Keeps a ring of future CDB cycles,
// grants issue to fixed-latency execution units whose result slot is free,
// and broadcasts the owning unit's result on a registered CDB when its slot
// arrives.
//   Build option CDB_SCHED_RR_EN: equal-latency contention is round-robin
//   (shared rr pointer); otherwise lowest unit index wins.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req, busy             per-unit issue request / cannot-accept
//   gnt                   per-unit issue grant (combinational)
//   res_valid/data/tag/sb per-unit result presented by the units
//   done                  per-unit pulse: result captured this cycle
//   cdb_valid/data/tag/sb registered broadcast
//   err                   sticky: reserved slot arrived without a result
module cdb_sched
    import cdb_sched_pkg::*;
#(
    parameter int unsigned             NUM_UNITS = 4,
    parameter int unsigned             MAX_LAT   = 8,
    parameter logic [4*NUM_UNITS-1:0]  UNIT_LAT  = DEF_UNIT_LAT,
    parameter int unsigned             DATA_W    = 32,
    parameter int unsigned             TAG_W     = 6,
    parameter int unsigned             SB_W      = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_UNITS-1:0]       req,
    input  logic [NUM_UNITS-1:0]       busy,
    output logic [NUM_UNITS-1:0]       gnt,
    input  logic [NUM_UNITS-1:0]       res_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] res_data,
    input  logic [NUM_UNITS*TAG_W-1:0] res_tag,
    input  logic [NUM_UNITS*SB_W-1:0]  res_sb,
    output logic [NUM_UNITS-1:0]       done,
    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [SB_W-1:0]            cdb_sb,
    output logic                       err
);

    function automatic int unsigned lat_of(input int unsigned u);
        return {28'd0, UNIT_LAT[4*u +: 4]};
    endfunction

    // Units whose latency equals l, i.e. that share ring slot l-1 on grant.
    function automatic logic [NUM_UNITS-1:0] lat_mask(input int unsigned l);
        logic [NUM_UNITS-1:0] m;
        m = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) m[u] = (lat_of(u) == l);
        return m;
    endfunction

    function automatic logic [OWNER_W-1:0] enc(input logic [NUM_UNITS-1:0] v);
        logic [OWNER_W-1:0] r;
        r = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) if (v[u]) r = OWNER_W'(u);
        return r;
    endfunction

    slot_t                own_r   [MAX_LAT];
    slot_t                own_nxt [MAX_LAT];
    logic [NUM_UNITS-1:0] elig;
    logic [NUM_UNITS-1:0] gnt_raw;
    logic [NUM_UNITS-1:0] gnt_by_lat [1:MAX_LAT];
    logic                 cap_hit;
    logic [DATA_W-1:0]    cap_data;
    logic [TAG_W-1:0]     cap_tag;
    logic [SB_W-1:0]      cap_sb;

`ifdef CDB_SCHED_RR_EN
    localparam int unsigned IDX_W = clog2(NUM_UNITS);
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_nxt;
    logic                 rr_upd;
    logic [NUM_UNITS-1:0] cwin;
    logic                 contested_by_lat [1:MAX_LAT];
`endif

    // Slot L-1 of the next ring is filled from own_r[L] shifting down, so a
    // latency-L unit may issue only if own_r[L] is empty (always free at MAX_LAT).
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        localparam int unsigned L = lat_of(u);
        if (L == MAX_LAT) begin : g_top
            assign elig[u] = req[u] & ~busy[u];
        end else begin : g_mid
            assign elig[u] = req[u] & ~busy[u] & ~own_r[L].valid;
        end
    end

    for (genvar l = 1; l <= MAX_LAT; l++) begin : g_lat
        localparam logic [NUM_UNITS-1:0] MASK = lat_mask(l);
        if (MASK != '0) begin : g_arb
            cdb_sched_arb #(.N(NUM_UNITS)) u_arb (
                .req       (elig & MASK),
`ifdef CDB_SCHED_RR_EN
                .ptr       (rr_ptr),
                .contested (contested_by_lat[l]),
`endif
                .gnt       (gnt_by_lat[l])
            );
        end else begin : g_none
            assign gnt_by_lat[l] = '0;
`ifdef CDB_SCHED_RR_EN
            assign contested_by_lat[l] = 1'b0;
`endif
        end
    end

    always_comb begin
        gnt_raw = '0;
        for (int unsigned l = 1; l <= MAX_LAT; l++) gnt_raw |= gnt_by_lat[l];
    end

    assign gnt = reset_n ? gnt_raw : '0;

    // At most one winner per latency, so each slot has at most one writer and
    // a written slot is guaranteed empty after the shift.
    for (genvar k = 0; k < MAX_LAT; k++) begin : g_slot
        localparam logic [NUM_UNITS-1:0] WMASK = lat_mask(k + 1);
        logic [NUM_UNITS-1:0] wr;
        slot_t                shifted;
        assign wr = gnt_raw & WMASK;
        if (k == MAX_LAT - 1) begin : g_top
            assign shifted = '0;
        end else begin : g_mid
            assign shifted = own_r[k + 1];
        end
        assign own_nxt[k] = (|wr) ? slot_t'{valid: 1'b1, owner: enc(wr)} : shifted;
    end

    always_comb begin
        done = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++)
            done[u] = reset_n & own_r[0].valid & (own_r[0].owner == OWNER_W'(u));
    end

    assign cap_hit = |(done & res_valid);

    always_comb begin
        cap_data = '0;
        cap_tag  = '0;
        cap_sb   = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (done[u]) begin
                cap_data = res_data[u*DATA_W +: DATA_W];
                cap_tag  = res_tag[u*TAG_W +: TAG_W];
                cap_sb   = res_sb[u*SB_W +: SB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < MAX_LAT; k++) own_r[k] <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            cdb_sb    <= '0;
            err       <= 1'b0;
        end else begin
            own_r     <= own_nxt;
            cdb_valid <= cap_hit;
            if (cap_hit) begin
                cdb_data <= cap_data;
                cdb_tag  <= cap_tag;
                cdb_sb   <= cap_sb;
            end
            if (own_r[0].valid && !cap_hit) err <= 1'b1;
        end
    end

`ifdef CDB_SCHED_RR_EN
    // Pointer moves past the highest-indexed winner of any contested slot.
    always_comb begin
        cwin   = '0;
        rr_upd = 1'b0;
        rr_nxt = rr_ptr;
        for (int unsigned l = 1; l <= MAX_LAT; l++)
            if (contested_by_lat[l]) cwin |= gnt_by_lat[l];
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (cwin[u]) begin
                rr_upd = 1'b1;
                rr_nxt = IDX_W'((u + 1) % NUM_UNITS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rr_ptr <= '0;
        else if (rr_upd) rr_ptr <= rr_nxt;
    end
`endif

endmodule
